iter_alu_md: RTL

- Parametrised, handshaked successor to the single-cycle integer ALU.
- Keeps the base RV32I op set, registered with 1-cycle latency.
- Adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) as iterative multi-cycle ops.
- Sits in EX. The pipeline stalls on in_ready=0 or on out_valid=1 with out_ready=0.

---
 rtl/iter_alu_md_if.sv | 24 ++
 rtl/iter_alu_md.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu_md_if.sv
// rtl/iter_alu_md_if.sv - request/response handshake bundle for iter_alu_md
interface iter_alu_md_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, in_a, in_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/iter_alu_md.sv
// rtl/iter_alu_md.sv - handshaked RV32I ALU with iterative M-extension ops
// ITER_ALU_FAST_MUL_EN swaps the shift-add multiplier for a single-cycle one.
module iter_alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic          clk,
  input logic          rst,
  iter_alu_md_if.slave bus
);

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_SLL    = 5'h04;
  localparam logic [4:0] OP_SRL    = 5'h05;
  localparam logic [4:0] OP_SRA    = 5'h06;
  localparam logic [4:0] OP_XOR    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_LUI    = 5'h0A;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0] a_in, b_in;
  logic [SHW-1:0]  shamt;
  logic            is_mul, is_div, signed_div;
  logic            neg_a, neg_b, neg_res, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] base_res;

  assign a_in  = bus.in_a;
  assign b_in  = bus.in_b;
  assign shamt = bus.in_b[SHW-1:0];

  // Operand classification: magnitudes feed both iterative engines, signs fix up the end.
  always_comb begin
    is_mul     = (bus.op[4:2] == 3'b100);
    is_div     = (bus.op[4:2] == 3'b101);
    signed_div = is_div && !bus.op[0];
    neg_a      = a_in[XLEN-1] &&
                 (is_mul ? (bus.op == OP_MULH || bus.op == OP_MULHSU) : signed_div);
    neg_b      = b_in[XLEN-1] && (is_mul ? (bus.op == OP_MULH) : signed_div);
    a_mag      = neg_a ? -a_in : a_in;
    b_mag      = neg_b ? -b_in : b_in;
    neg_res    = (is_div && bus.op[1]) ? neg_a : (neg_a ^ neg_b);
    div_ovf    = signed_div && (a_in == INT_MIN) && (b_in == '1);
  end

  always_comb begin
    base_res = '0;
    case (bus.op)
      OP_ADD:  base_res = a_in + b_in;
      OP_SUB:  base_res = a_in - b_in;
      OP_AND:  base_res = a_in & b_in;
      OP_OR:   base_res = a_in | b_in;
      OP_SLL:  base_res = a_in << shamt;
      OP_SRL:  base_res = a_in >> shamt;
      OP_SRA:  base_res = $signed(a_in) >>> shamt;
      OP_XOR:  base_res = a_in ^ b_in;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a_in < b_in};
      OP_LUI:  base_res = b_in;
      default: base_res = '0;
    endcase
  end

`ifdef ITER_ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Sign-extending to 2*XLEN makes the low 2*XLEN bits of the product exact for every variant.
  always_comb begin
    fast_a    = {{XLEN{neg_a}}, a_in};
    fast_b    = {{XLEN{neg_b}}, b_in};
    fast_prod = fast_a * fast_b;
    fast_res  = (bus.op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // acc_q holds {partial product, remaining multiplier} or {remainder, quotient}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_prod;
  logic [XLEN-1:0]   mul_fin;
  logic [XLEN:0]     div_rem_sh, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_quo, div_rem, div_fin;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    mul_prod = neg_q ? -mul_next : mul_next;
    mul_fin  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
    div_diff   = div_rem_sh - {1'b0, mcand_q};
    div_next   = div_diff[XLEN] ? {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    div_quo    = div_next[XLEN-1:0];
    div_rem    = div_next[2*XLEN-1:XLEN];
    if (op_q[1]) begin
      div_fin = neg_q ? -div_rem : div_rem;
    end else begin
      div_fin = neg_q ? -div_quo : div_quo;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.op;
          cnt_d = '0;
          if (is_mul) begin
`ifdef ITER_ALU_FAST_MUL_EN
            result_d = fast_res;
            state_d  = S_DONE;
`else
            acc_d   = {{XLEN{1'b0}}, b_mag};
            mcand_d = a_mag;
            neg_d   = neg_res;
            state_d = S_MUL;
`endif
          end else if (is_div) begin
            if (b_in == '0) begin
              result_d = bus.op[1] ? a_in : '1;
              state_d  = S_DONE;
            end else if (div_ovf) begin
              result_d = bus.op[1] ? '0 : a_in;
              state_d  = S_DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, a_mag};
              mcand_d = b_mag;
              neg_d   = neg_res;
              state_d = S_DIV;
            end
          end else begin
            result_d = base_res;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN-1)) begin
          result_d = mul_fin;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN-1)) begin
          result_d = div_fin;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.result    = result_q;

endmodule
